loop_add_4_pipe: RTL and testbench
==================================

Name: loop_add_4_pipe

Overview:
- Pipelined HLS-style loop kernel computing a[i] = b[i] + 4 for i = 0..5 over one external single-write, single-read 32-bit word memory.
- a starts at word address 0; b starts at word address 10.
- Issues one iteration per cycle (II=1) through a 5-stage pipeline.
- Raises valid once every iteration has retired.

Parameters:
- N_ITERS, 6, loop trip count.
- SRC_BASE, 10, word address of b[0].
- DST_BASE, 0, word address of a[0].
- ADDEND, 4, constant added to each element.
- ADDR_W, 5, memory address width.
- DATA_W, 32, memory data width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- valid  output  1  done flag; high once all iterations have retired.
- raddr_0  output  ADDR_W  memory read address.
- rdata_0  input  DATA_W  memory read data; synchronous memory, valid the cycle after raddr_0 is presented.
- waddr_0  output  ADDR_W  memory write address.
- wdata_0  output  DATA_W  memory write data.
- wen_0  output  1  memory write enable; write commits on the rising clk edge while high.

Behaviour:
- Reset (rst low, async): iteration counter = 0, all stage-valid bits = 0, valid = 0, wen_0 = 0, raddr_0 = SRC_BASE, waddr_0 = 0, wdata_0 = 0.
- While in reset, wen_0 must stay 0 so other masters can preload memory.
- Start: first rising edge after rst goes high places iteration 0 in S1. Each following edge issues the next iteration into S1 until N_ITERS iterations have been issued.
- Stage S1: drive raddr_0 = SRC_BASE + i.
- Stage S2: rdata_0 holds b[i]; register it.
- Stage S3: sum = b[i] + ADDEND. Width DATA_W, modulo 2^DATA_W, no saturation.
- Stage S4: drive waddr_0 = DST_BASE + i, wdata_0 = sum, wen_0 = 1. The write commits at the end of S4.
- Stage S5: retire. Pipeline bubbles hold wen_0 = 0.
- Per-stage valid bit plus per-stage iteration index register; stages advance every cycle with no stalls.
- Timing, counted in edges after reset release:
  - Iteration k occupies S1 at edge k+1 and S5 at edge k+5.
  - Iteration 5 is in S5 after edge 10; valid is still 0 then, and a[0] already holds b[0]+4.
  - valid = 1 after edge 11.
- Once high, valid stays 1 until the next reset. No further memory writes occur (wen_0 = 0); memory contents are stable.
- Single-port write only: at most one write per cycle, never two iterations in S4.
- Reads and writes target disjoint regions (0..5 vs 10..15), so no RAW hazard handling is required.
- Reset mid-operation: pipeline flushes immediately, valid = 0, wen_0 = 0. After release the loop restarts from i = 0. Words already written stay as written.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.

Test Plan:
- Preload b[0]=10, b[1]=5 (addresses 10, 11) while rst low; release rst -> after 10 edges valid=0 and mem[0]=14; after 11 edges valid=1 and mem[1]=9.
- Continue 18+ extra clocks after done -> valid stays 1, mem[0]=14, mem[1]=9 unchanged, wen_0 never high.
- Preload b[0..5] = 0, 1, 0xFFFFFFFF, 100, 7, 0xFFFFFFFC -> a = 4, 5, 3, 104, 11, 0 (wrap-around check).
- Monitor ports per cycle -> raddr_0 = 10..15 on edges 1..6; wen_0 high exactly 6 consecutive cycles with waddr_0 = 0..5 in order.
- Assert rst low after edge 3, hold 2 cycles, release -> valid=0 during reset, wen_0=0; full run restarts from i=0, valid after 11 edges, final a correct.
- Hold rst low for many clocks while preloading memory -> no writes from the block; valid stays 0.

Source files
------------

// File: rtl/loop_add_4_pipe.sv
// loop_add_4_pipe: pipelined loop kernel a[i] = b[i] + ADDEND, i = 0..N_ITERS-1, II=1, 5 stages
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   valid    done flag, high once every iteration has retired, held until reset
//   raddr_0  memory read address (S1)
//   rdata_0  synchronous memory read data, valid the cycle after raddr_0
//   waddr_0  memory write address (S4)
//   wdata_0  memory write data (S4)
//   wen_0    memory write enable, write commits on the rising edge while high
module loop_add_4_pipe #(
    parameter int N_ITERS  = 6,
    parameter int SRC_BASE = 10,
    parameter int DST_BASE = 0,
    parameter int ADDEND   = 4,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              valid,
    output logic [ADDR_W-1:0] raddr_0,
    input  logic [DATA_W-1:0] rdata_0,
    output logic [ADDR_W-1:0] waddr_0,
    output logic [DATA_W-1:0] wdata_0,
    output logic              wen_0
);
    localparam int IW = $clog2(N_ITERS + 1);

    logic [IW-1:0]     cnt, s1_i, s2_i, s3_i, s4_i, s5_i;
    logic              s1_v, s2_v, s3_v, s5_v;
    logic [DATA_W-1:0] b_q;
    logic              issue;

    assign issue = cnt != IW'(N_ITERS);

    // wen_0 doubles as the S4 valid bit; raddr/waddr/wdata are the S1/S4 registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s3_v    <= 1'b0;
            s5_v    <= 1'b0;
            s1_i    <= '0;
            s2_i    <= '0;
            s3_i    <= '0;
            s4_i    <= '0;
            s5_i    <= '0;
            b_q     <= '0;
            valid   <= 1'b0;
            wen_0   <= 1'b0;
            raddr_0 <= ADDR_W'(SRC_BASE);
            waddr_0 <= '0;
            wdata_0 <= '0;
        end else begin
            s1_v    <= issue;
            cnt     <= issue ? cnt + 1'b1 : cnt;
            s1_i    <= cnt;
            raddr_0 <= issue ? ADDR_W'(SRC_BASE) + ADDR_W'(cnt) : raddr_0;
            s2_v    <= s1_v;
            s2_i    <= s1_i;
            s3_v    <= s2_v;
            s3_i    <= s2_i;
            b_q     <= rdata_0;
            wen_0   <= s3_v;
            s4_i    <= s3_i;
            waddr_0 <= ADDR_W'(DST_BASE) + ADDR_W'(s3_i);
            wdata_0 <= b_q + DATA_W'(ADDEND);
            s5_v    <= wen_0;
            s5_i    <= s4_i;
            valid   <= valid | (s5_v && s5_i == IW'(N_ITERS - 1));
        end
    end
endmodule

// File: tb/tb_loop_add_4_pipe.sv
// tb_loop_add_4_pipe: directed bench for loop_add_4_pipe with a synchronous memory model
module tb_loop_add_4_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid;
    logic [4:0]  raddr_0, waddr_0;
    logic [31:0] rdata_0, wdata_0;
    logic        wen_0;

    logic [31:0] mem [32];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          wr_cnt = 0;
    int          rst_wr = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] b1 [6] = '{32'd10, 32'd5, 32'd0, 32'd1, 32'd2, 32'd3};
    logic [31:0] b2 [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd100, 32'd7, 32'hFFFF_FFFC};
    logic [31:0] a2 [6] = '{32'd4, 32'd5, 32'd3, 32'd104, 32'd11, 32'd0};
    logic [31:0] b3 [6] = '{32'd20, 32'd21, 32'd22, 32'd23, 32'd24, 32'd25};

    always #5 clk = ~clk;

    loop_add_4_pipe dut (
        .clk(clk), .rst(rst), .valid(valid), .raddr_0(raddr_0), .rdata_0(rdata_0),
        .waddr_0(waddr_0), .wdata_0(wdata_0), .wen_0(wen_0)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (wen_0) mem[waddr_0] <= wdata_0;
        if (wen_0) wr_cnt <= wr_cnt + 1;
        if (wen_0 && !rst) rst_wr <= rst_wr + 1;
        rdata_0 <= mem[raddr_0];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic load(input logic [31:0] b [6]);
        for (int i = 0; i < 6; i++) begin
            poke(5'(10 + i), b[i]);
            poke(5'(i), 32'hDEAD_0000);
        end
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] a [6]);
        int w0;
        w0 = wr_cnt;
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            #1;
            if (e == 10) check({tag, "_valid_e10"}, 64'(valid), 64'd0);
        end
        check({tag, "_valid_e11"}, 64'(valid), 64'd1);
        check({tag, "_writes"}, 64'(wr_cnt - w0), 64'd6);
        for (int i = 0; i < 6; i++) check({tag, "_a"}, 64'(mem[i]), 64'(a[i]));
    endtask

    initial begin
        logic [31:0] a1 [6];
        int w0;
        for (int i = 0; i < 6; i++) a1[i] = b1[i] + 32'd4;
        // run 1: per-cycle port monitor
        load(b1);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_wen", 64'(wen_0), 64'd0);
        check("rst_raddr", 64'(raddr_0), 64'd10);
        check("rst_waddr", 64'(waddr_0), 64'd0);
        check("rst_wdata", 64'(wdata_0), 64'd0);
        release_rst();
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            #1;
            if (e <= 6) check("raddr", 64'(raddr_0), 64'(10 + e - 1));
            check("wen", 64'(wen_0), 64'(e >= 4 && e <= 9));
            if (e >= 4 && e <= 9) begin
                check("waddr", 64'(waddr_0), 64'(e - 4));
                check("wdata", 64'(wdata_0), 64'(a1[e-4]));
            end
            check("valid", 64'(valid), 64'(e >= 11));
            if (e == 10) check("mem0_e10", 64'(mem[0]), 64'd14);
            if (e == 11) check("mem1_e11", 64'(mem[1]), 64'd9);
        end
        w0 = wr_cnt;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            check("done_valid", 64'(valid), 64'd1);
            check("done_wen", 64'(wen_0), 64'd0);
        end
        check("done_writes", 64'(wr_cnt - w0), 64'd0);
        for (int i = 0; i < 6; i++) check("run1_a", 64'(mem[i]), 64'(a1[i]));
        // run 2: long reset with preload, wrap-around data
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst2_valid", 64'(valid), 64'd0);
        load(b2);
        repeat (10) @(posedge clk);
        check("rst2_valid_hold", 64'(valid), 64'd0);
        check("rst2_no_writes", 64'(rst_wr), 64'd0);
        release_rst();
        run_and_check("wrap", a2);
        // run 3: reset asserted mid-run after edge 3
        @(negedge clk);
        rst = 1'b0;
        load(b3);
        release_rst();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_valid", 64'(valid), 64'd0);
        check("mid_wen", 64'(wen_0), 64'd0);
        check("mid_raddr", 64'(raddr_0), 64'd10);
        repeat (2) @(posedge clk);
        #1 check("mid_wen_hold", 64'(wen_0), 64'd0);
        for (int i = 0; i < 6; i++) a1[i] = b3[i] + 32'd4;
        release_rst();
        run_and_check("restart", a1);
        check("no_writes_in_rst", 64'(rst_wr), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
